// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, shift, rotate and clear, plus a
// multi-cycle burst rotate-left by a programmable amount with busy/done status.
module univ_shift_reg #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
   parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}},
   parameter int               CW      = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             set_b,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic [CW-1:0]    amt,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   localparam logic [2:0] M_HOLD  = 3'b000;
   localparam logic [2:0] M_LOAD  = 3'b001;
   localparam logic [2:0] M_SHL   = 3'b010;
   localparam logic [2:0] M_SHR   = 3'b011;
   localparam logic [2:0] M_ROL   = 3'b100;
   localparam logic [2:0] M_ROR   = 3'b101;
   localparam logic [2:0] M_CLR   = 3'b110;
   localparam logic [2:0] M_BURST = 3'b111;

   logic [WIDTH-1:0] q_q,     q_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [1:0]       state_q, state_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;
   logic [WIDTH-1:0] rol_q;

   assign rol_q = {q_q[WIDTH-2:0], q_q[WIDTH-1]};

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      q_d     = q_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               case (mode)
                  M_HOLD:  q_d = q_q;
                  M_LOAD:  q_d = d;
                  M_SHL:   q_d = {q_q[WIDTH-2:0], sin_r};
                  M_SHR:   q_d = {sin_l, q_q[WIDTH-1:1]};
                  M_ROL:   q_d = rol_q;
                  M_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
                  M_CLR:   q_d = RST_VAL;
                  M_BURST: begin
                     cnt_d   = amt;
                     state_d = (amt == '0) ? ST_FIN : ST_RUN;
                  end
                  default: q_d = q_q;
               endcase
            end
         end
         ST_RUN: begin
            // The edge that sees cnt==1 performs the final rotate.
            q_d   = rol_q;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = ST_FIN;
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_FIN);
   end

   // Set outranks reset; either one aborts a burst without a done pulse.
   always_ff @(posedge clk or negedge set_b or negedge rst_b) begin
      if (!set_b) begin
         // NOTE: registers use non-blocking assignments so all state updates see pre-edge values.
         q_q     <= SET_VAL;
         cnt_q   <= '0;
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (!rst_b) begin
         q_q     <= RST_VAL;
         cnt_q   <= '0;
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign q      = q_q;
   assign sout_l = q_q[WIDTH-1];
   assign sout_r = q_q[0];
   assign zero   = (q_q == '0);
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: a table of single-cycle operations, then
// hand-written burst, zero-amount and abort-by-reset sequences.
module tb_univ_shift_reg;

   localparam logic [2:0] M_HOLD  = 3'b000;
   localparam logic [2:0] M_LOAD  = 3'b001;
   localparam logic [2:0] M_SHL   = 3'b010;
   localparam logic [2:0] M_SHR   = 3'b011;
   localparam logic [2:0] M_ROL   = 3'b100;
   localparam logic [2:0] M_ROR   = 3'b101;
   localparam logic [2:0] M_CLR   = 3'b110;
   localparam logic [2:0] M_BURST = 3'b111;

   logic       clk = 1'b0;
   logic       rst_b, set_b, en, sin_l, sin_r;
   logic [2:0] mode, amt;
   logic [7:0] d, q;
   logic       sout_l, sout_r, zero, busy, done;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string      name;
      logic       en;
      logic [2:0] mode;
      logic [7:0] d;
      logic       sin_l;
      logic       sin_r;
      logic [7:0] exp_q;
   } vec_t;

   vec_t vecs[$];

   univ_shift_reg #(.WIDTH(8)) dut (
      .clk(clk), .rst_b(rst_b), .set_b(set_b), .en(en), .mode(mode), .d(d),
      .amt(amt), .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout_l(sout_l),
      .sout_r(sout_r), .zero(zero), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input string name, input logic e, input logic [2:0] m,
                          input logic [7:0] dv, input logic sl, input logic sr,
                          input logic [7:0] eq);
      vec_t v;
      v.name = name; v.en = e; v.mode = m; v.d = dv;
      v.sin_l = sl; v.sin_r = sr; v.exp_q = eq;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic e, input logic [2:0] m, input logic [7:0] dv,
                        input logic [2:0] a);
      @(negedge clk);
      en = e; mode = m; d = dv; amt = a;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_q(input string name, input logic [7:0] eq);
      check({name, "_q"}, q, eq);
      check({name, "_sout_l"}, sout_l, eq[7]);
      check({name, "_sout_r"}, sout_r, eq[0]);
      check({name, "_zero"}, zero, eq == 8'h00);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_b = 1'b1; set_b = 1'b1; en = 1'b0; mode = M_HOLD; d = 8'h00;
      amt = 3'd0; sin_l = 1'b0; sin_r = 1'b0;

      // Set and reset together: set wins.
      #1;
      set_b = 1'b0; rst_b = 1'b0;
      #1;
      check("both_low_q", q, 8'hFF);
      check("both_low_busy", busy, 1'b0);
      check("both_low_done", done, 1'b0);
      set_b = 1'b1;
      cycle();
      check("rst_only_q", q, 8'h00);
      check("rst_only_zero", zero, 1'b1);
      @(negedge clk);
      rst_b = 1'b1;

      add_vec("load_a5",  1, M_LOAD, 8'hA5, 0, 0, 8'hA5);
      add_vec("shl_1",    1, M_SHL,  8'h00, 0, 1, 8'h4B);
      add_vec("shr_0",    1, M_SHR,  8'h00, 0, 0, 8'h25);
      add_vec("load_81",  1, M_LOAD, 8'h81, 0, 0, 8'h81);
      add_vec("rol",      1, M_ROL,  8'h00, 0, 0, 8'h03);
      add_vec("ror",      1, M_ROR,  8'h00, 0, 0, 8'h81);
      add_vec("clr",      1, M_CLR,  8'hFF, 1, 1, 8'h00);
      add_vec("en0_load", 0, M_LOAD, 8'hFF, 0, 0, 8'h00);
      add_vec("load_3c",  1, M_LOAD, 8'h3C, 0, 0, 8'h3C);
      add_vec("shr_1",    1, M_SHR,  8'h00, 1, 0, 8'h9E);
      add_vec("shl_0",    1, M_SHL,  8'h00, 1, 0, 8'h3C);
      add_vec("hold",     1, M_HOLD, 8'hFF, 1, 1, 8'h3C);
      add_vec("ror_3c",   1, M_ROR,  8'h00, 0, 0, 8'h1E);
      add_vec("rol_1e",   1, M_ROL,  8'h00, 0, 0, 8'h3C);

      foreach (vecs[i]) begin
         drive(vecs[i].en, vecs[i].mode, vecs[i].d, 3'd0);
         sin_l = vecs[i].sin_l; sin_r = vecs[i].sin_r;
         cycle();
         check_q(vecs[i].name, vecs[i].exp_q);
         check({vecs[i].name, "_busy"}, busy, 1'b0);
      end

      // Rotate by WIDTH through single ROL steps returns the original word.
      for (int i = 0; i < 8; i++) begin
         drive(1, M_ROL, 8'h00, 3'd0);
         cycle();
      end
      check("rol_wrap_q", q, 8'h3C);

      // Burst amt=3 from 0x01; mode/d changes during RUN and FIN are ignored.
      drive(1, M_LOAD, 8'h01, 3'd0);
      cycle();
      check("burst_pre_q", q, 8'h01);
      drive(1, M_BURST, 8'h00, 3'd3);
      cycle();
      check("burst_c1_busy", busy, 1'b1);
      check("burst_c1_done", done, 1'b0);
      check("burst_c1_q", q, 8'h01);
      drive(1, M_LOAD, 8'hFF, 3'd7);
      cycle();
      check("burst_c2_busy", busy, 1'b1);
      check("burst_c2_q", q, 8'h02);
      cycle();
      check("burst_c3_busy", busy, 1'b1);
      check("burst_c3_q", q, 8'h04);
      drive(1, M_CLR, 8'hFF, 3'd0);
      cycle();
      check("burst_fin_busy", busy, 1'b0);
      check("burst_fin_done", done, 1'b1);
      check("burst_fin_q", q, 8'h08);
      drive(1, M_LOAD, 8'hFF, 3'd0);
      cycle();
      check("burst_after_done", done, 1'b0);
      check("burst_after_busy", busy, 1'b0);
      check("burst_after_q", q, 8'h08);

      // Burst amt=0: done on the next cycle, q untouched, busy never set.
      drive(1, M_BURST, 8'h00, 3'd0);
      cycle();
      check("amt0_busy", busy, 1'b0);
      check("amt0_done", done, 1'b1);
      check("amt0_q", q, 8'h08);
      drive(0, M_HOLD, 8'h00, 3'd0);
      cycle();
      check("amt0_after_done", done, 1'b0);
      check("amt0_after_busy", busy, 1'b0);

      // Burst amt=5 aborted by rst_b after two rotates.
      drive(1, M_LOAD, 8'h01, 3'd0);
      cycle();
      drive(1, M_BURST, 8'h00, 3'd5);
      cycle();
      drive(0, M_HOLD, 8'h00, 3'd0);
      cycle();
      cycle();
      check("abort_pre_q", q, 8'h04);
      check("abort_pre_busy", busy, 1'b1);
      #2;
      rst_b = 1'b0;
      #1;
      check("abort_q", q, 8'h00);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      @(negedge clk);
      rst_b = 1'b1;
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 8; i++) begin
            cycle();
            if (done || busy) seen = 1'b1;
         end
         check("abort_no_done", seen, 1'b0);
      end
      check("abort_q_held", q, 8'h00);
      drive(1, M_LOAD, 8'h5A, 3'd0);
      cycle();
      check_q("post_abort_load", 8'h5A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
